// File: rtl/clock_div_prog_multi.sv
// clock_div_prog_multi: NUM_CH runtime-programmable clock dividers with per-period tick
// strobes, per-channel enable and a common in-phase restart.
module clock_div_prog_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 17,
    parameter int DEFAULT_DIV = 10
) (
    input  logic              CLK_1MHZ_IN,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] CH_EN,
    input  logic [NUM_CH-1:0] DIV_LOAD,
    input  logic [CNT_W-1:0]  DIV_VALUE,
    input  logic              SYNC_START,
    output logic [NUM_CH-1:0] CLK_OUT,
    output logic [NUM_CH-1:0] TICK_OUT,
    output logic              DIV_ERR
);
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  act_q [NUM_CH];
    logic [CNT_W-1:0]  act_d [NUM_CH];
    logic [CNT_W-1:0]  pend_q [NUM_CH];
    logic [CNT_W-1:0]  pend_d [NUM_CH];
    logic [CNT_W-1:0]  nd [NUM_CH];
    logic [CNT_W-1:0]  hi [NUM_CH];
    logic [CNT_W-1:0]  inc [NUM_CH];
    logic [NUM_CH-1:0] pflag_q, pflag_d, clk_q, clk_d, tick_q, tick_d, hist_q, hist_d;
    logic [NUM_CH-1:0] ld, restart, apply;
    logic              err_q, err_d, ld_ok;

    always_comb begin
        ld_ok  = DIV_VALUE > CNT_W'(1);
        ld     = DIV_LOAD & {NUM_CH{ld_ok}};
        err_d  = (|DIV_LOAD) & ~ld_ok;
        hist_d = CH_EN;
        for (int i = 0; i < NUM_CH; i++) begin
            // A load in the same cycle as a restart wins over any older pending value
            nd[i]         = ld[i] ? DIV_VALUE : pflag_q[i] ? pend_q[i] : act_q[i];
            hi[i]         = act_q[i] - (act_q[i] >> 1);
            inc[i]        = cnt_q[i] + CNT_W'(1);
            restart[i]    = CH_EN[i] & (~hist_q[i] | SYNC_START | (inc[i] == act_q[i]));
            apply[i]      = ~CH_EN[i] | restart[i];
            act_d[i]      = apply[i] ? nd[i] : act_q[i];
            pflag_d[i]    = apply[i] ? 1'b0 : (pflag_q[i] | ld[i]);
            pend_d[i]     = ld[i] ? DIV_VALUE : pend_q[i];
            cnt_d[i]      = (CH_EN[i] & ~restart[i]) ? inc[i] : '0;
            clk_d[i]      = restart[i] | (CH_EN[i] & clk_q[i] & (inc[i] != hi[i]));
            tick_d[i]     = restart[i];
        end
    end

    always_ff @(posedge CLK_1MHZ_IN or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                act_q[i]  <= CNT_W'(DEFAULT_DIV);
                pend_q[i] <= CNT_W'(DEFAULT_DIV);
            end
            pflag_q <= '0;
            clk_q   <= '0;
            tick_q  <= '0;
            hist_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            pflag_q <= pflag_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            hist_q  <= hist_d;
            err_q   <= err_d;
        end
    end

    assign CLK_OUT  = clk_q;
    assign TICK_OUT = tick_q;
    assign DIV_ERR  = err_q;
endmodule

// File: doc/clock_div_prog_multi.md
Name: clock_div_prog_multi

Overview:
Multi-channel programmable clock divider driven from the 1 MHz system clock. It generates NUM_CH independent divided clocks, each with a runtime-loadable divisor. Each channel also provides a one-cycle tick strobe at the start of every output period. Channels can be individually enabled and phase-aligned together with a single sync pulse. It replaces the fixed single-ratio dividers that feed the sensor, telemetry and bus-timing logic.

Parameters:
NUM_CH, 4, number of independent output channels (1..8)
CNT_W, 17, width of divisor and per-channel counter
DEFAULT_DIV, 10, divisor loaded into every channel at reset (must be >= 2)

Ports:
CLK_1MHZ_IN  input  1  system clock, all logic on rising edge
RESET  input  1  asynchronous, active-low reset
CH_EN  input  NUM_CH  per-channel enable, level-sensitive
DIV_LOAD  input  NUM_CH  per-channel one-cycle strobe: capture DIV_VALUE
DIV_VALUE  input  CNT_W  divisor N, in input-clock cycles per output period
SYNC_START  input  1  one-cycle strobe: restart all enabled channels in phase
CLK_OUT  output  NUM_CH  divided clocks, registered, glitch-free
TICK_OUT  output  NUM_CH  one-cycle pulse coincident with each CLK_OUT rising edge
DIV_ERR  output  1  one-cycle pulse: rejected divisor load

Behaviour:
- Reset (RESET=0, async): CLK_OUT=0, TICK_OUT=0, DIV_ERR=0, all counters=0, active divisor=DEFAULT_DIV, pending divisor=DEFAULT_DIV, pending flags clear, internal enable history=0.
- Per channel: active divisor N, HI=N-N/2 (ceil), counter cnt in 0..N-1.
  - Output high for HI cycles, low for N-HI cycles. Examples: N=10 gives 5/5; N=3 gives 2/1; N=2 gives 1/1.
- Start: at the edge where CH_EN[i] is first sampled 1 (previous sample 0), cnt<=0, CLK_OUT[i]<=1, TICK_OUT[i]<=1.
- Run, each edge while enabled:
  - If cnt==N-1: period boundary. cnt<=0, CLK_OUT<=1, TICK_OUT<=1; any pending divisor becomes active first.
  - Else: cnt<=cnt+1; CLK_OUT<=0 when cnt+1==HI; TICK_OUT<=0.
- Disable: on the edge CH_EN[i] is sampled 0, CLK_OUT[i]<=0, TICK_OUT[i]<=0, cnt<=0 immediately. Truncating the high phase is allowed.
- Divisor load: DIV_LOAD[i]=1 with DIV_VALUE>=2 writes pending[i].
  - Channel enabled: the value takes effect at the next period boundary, so there are no runt periods.
  - Channel disabled: the value becomes active immediately.
  - Several DIV_LOAD bits set at once load the same value into each selected channel.
  - Repeated loads before a boundary: last one wins.
- Invalid load: DIV_VALUE<2 is rejected. Channel state is unchanged; DIV_ERR=1 for exactly one cycle on the following edge. Multiple rejected bits in one cycle still give a single pulse.
- SYNC_START=1: every channel with CH_EN=1 behaves as at start (cnt<=0, CLK_OUT<=1, TICK<=1) on that edge. Pending divisors are applied first.
  - Disabled channels ignore SYNC_START.
- Simultaneous events:
  - SYNC_START with a load to the same channel: the new value is used for the restarted period.
  - CH_EN rising with a load: the new value is used from the first period.
  - SYNC_START during a boundary: identical result, one tick only.
- Latency: CLK_OUT/TICK_OUT change on the same edge that samples the controlling input. There is no extra pipeline stage.
- Reset mid-operation: all outputs drop within the async path. After release, enabled channels restart at the first edge, counted as a start event since the enable history resets to 0. Divisors revert to DEFAULT_DIV.

Test Plan:
- Reset release with CH_EN=4'b0001, default N=10 -> CLK_OUT[0] 5 high/5 low, TICK_OUT[0] one pulse every 10 cycles, other channels stay 0.
- Load N=3 on ch1 while enabled mid-period -> current 10-cycle period completes, then 2 high/1 low pattern, no short pulse.
- DIV_LOAD with DIV_VALUE=1, then 0 -> DIV_ERR pulses once per attempt one cycle later, ch period unchanged at 10.
- Ch0 N=4, ch1 N=6, both running; assert SYNC_START -> both CLK_OUT rise and TICK_OUT pulse on the same edge, then rise together again after 12 cycles.
- Deassert CH_EN[2] during high phase, reassert 3 cycles later -> output 0 on disable edge, full fresh high phase from the re-enable edge.
- Pull RESET low mid-period, release -> outputs 0 immediately, divisors back to 10, first tick on the first edge after release.
